// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants and state type for the matmul result path
package matmul_pkg;

  localparam int DWIDTH    = 16;
  localparam int AWIDTH    = 7;
  localparam int MAT_SIZE  = 4;
  localparam int NUM_DIAGS = 2 * MAT_SIZE - 1;

  // Index helpers: last anti-diagonal word and last row of the matrix.
  localparam int LAST_DIAG = NUM_DIAGS - 1;
  localparam int LAST_ROW  = MAT_SIZE - 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/matc_diag_unpacker.sv
// rtl/matc_diag_unpacker.sv - rebuilds an anti-diagonal packed 4x4 C matrix into row-major rows
module matc_diag_unpacker #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 7,
  parameter int MAT_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [AWIDTH-1:0]     base_addr,
  output logic                  mem_rd_en,
  output logic [AWIDTH-1:0]     mem_addr,
  input  logic [4*DWIDTH-1:0]   mem_rdata,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [4*DWIDTH-1:0]   row_data,
  output logic [1:0]            row_idx,
  output logic                  busy,
  output logic                  done
);

  import matmul_pkg::*;

  state_t              state;
  logic [2:0]          diag;
  logic                cap_vld;
  logic [2:0]          cap_diag;
  logic [DWIDTH-1:0]   elem [MAT_SIZE][MAT_SIZE];
  logic [1:0]          next_idx;
  logic [4*DWIDTH-1:0] next_row;

  // Row to load on the next transition: row 0 out of DRAIN, otherwise the following row.
  assign next_idx = (state == OUT) ? row_idx + 2'd1 : 2'd0;

  always_comb begin
    next_row = '0;
    for (int c = 0; c < MAT_SIZE; c++) begin
      next_row[c*DWIDTH +: DWIDTH] = elem[next_idx][c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      diag      <= '0;
      cap_vld   <= 1'b0;
      cap_diag  <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      row_valid <= 1'b0;
      row_data  <= '0;
      row_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // RAM data lags the address by one cycle, so qualify it with a delayed strobe/index.
      cap_vld  <= mem_rd_en;
      cap_diag <= diag;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            diag      <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            row_idx   <= '0;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (diag == 3'(LAST_DIAG)) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            diag     <= diag + 3'd1;
            mem_addr <= mem_addr + AWIDTH'(1);
          end
        end
        DRAIN: begin
          state     <= OUT;
          row_valid <= 1'b1;
          row_data  <= next_row;
          row_idx   <= next_idx;
        end
        OUT: begin
          if (row_ready) begin
            if (row_idx == 2'(LAST_ROW)) begin
              row_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              row_data <= next_row;
              row_idx  <= next_idx;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane k of diagonal word d carries C[k][d-k]; any lane with no matching column is padding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < MAT_SIZE; r++) begin
        for (int c = 0; c < MAT_SIZE; c++) begin
          elem[r][c] <= '0;
        end
      end
    end else if (cap_vld) begin
      for (int k = 0; k < MAT_SIZE; k++) begin
        for (int c = 0; c < MAT_SIZE; c++) begin
          if (int'(cap_diag) == k + c) begin
            elem[k][c] <= mem_rdata[k*DWIDTH +: DWIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matc_diag_unpacker.sv
// tb/tb_matc_diag_unpacker.sv - self-checking bench for matc_diag_unpacker
module tb_matc_diag_unpacker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  base_addr;
  logic        mem_rd_en;
  logic [6:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic        row_valid;
  logic        row_ready;
  logic [63:0] row_data;
  logic [1:0]  row_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  matc_diag_unpacker #(.DWIDTH(16), .AWIDTH(7), .MAT_SIZE(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .busy(busy), .done(done)
  );

  logic [63:0] ram [0:127];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int tests = 0;
  int fails = 0;

  logic [15:0] mat [0:3][0:3];
  int          addr_cyc[$];
  logic [6:0]  addr_val[$];
  logic [63:0] row_got[$];
  logic [1:0]  idx_got[$];
  int          row_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          unstable;
  bit          busy_log [0:255];

  function automatic logic [63:0] exp_row(input int r);
    return {mat[r][3], mat[r][2], mat[r][1], mat[r][0]};
  endfunction

  task automatic set_basic_matrix();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mat[i][j] = 16'(16 * i + j);
  endtask

  task automatic set_random_matrix();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mat[i][j] = 16'($urandom);
  endtask

  // Pack the model matrix into 7 anti-diagonal words starting at base.
  task automatic load_matrix(input logic [6:0] base, input bit rand_pad);
    logic [63:0] w;
    logic [6:0]  a;
    for (int d = 0; d < 7; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (d - k >= 0 && d - k <= 3) w[k*16 +: 16] = mat[k][d-k];
        else w[k*16 +: 16] = rand_pad ? 16'($urandom) : 16'hDEAD;
      end
      a = base + 7'(d);
      ram[a] = w;
    end
  endtask

  task automatic run_transfer(input logic [6:0] base, input int stall, input int busy_start_cyc);
    int          stall_left;
    bit          holding;
    logic [63:0] held;
    logic [1:0]  held_idx;
    addr_cyc.delete(); addr_val.delete(); row_got.delete(); idx_got.delete(); row_cyc.delete();
    done_cnt = 0; done_cyc = -1; unstable = 0; holding = 0; stall_left = stall;
    for (int i = 0; i < 256; i++) busy_log[i] = 1'b0;
    @(negedge clk);
    base_addr = base; start = 1'b1; row_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 7'd0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      busy_log[cyc] = busy;
      if (mem_rd_en) begin addr_cyc.push_back(cyc); addr_val.push_back(mem_addr); end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (row_valid) begin
        if (!holding) begin held = row_data; held_idx = row_idx; holding = 1; end
        else if (row_data !== held || row_idx !== held_idx) unstable++;
        if (stall_left > 0) begin row_ready = 1'b0; stall_left--; end
        else row_ready = 1'b1;
        if (row_ready) begin
          row_got.push_back(row_data); idx_got.push_back(row_idx); row_cyc.push_back(cyc);
          holding = 0; stall_left = stall;
        end
      end
      if (cyc == busy_start_cyc) begin start = 1'b1; base_addr = 7'd40; end
      else start = 1'b0;
      if (done_cyc >= 0 && cyc >= done_cyc + 10) break;
    end
    start = 1'b0; row_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0; row_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) ram[i] = 64'h0;
    repeat (3) @(negedge clk);
    tests++;
    if ({mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%b addr=%0d v=%b data=%h idx=%0d busy=%b done=%b want all 0",
               mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_basic_matrix();
    load_matrix(7'd0, 1'b0);
    run_transfer(7'd0, 0, -1);
    tests++;
    if (addr_val.size() !== 7) begin
      fails++; $display("FAIL basic_addr_count: got %0d want 7", addr_val.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++;
        if (addr_val[i] !== 7'(i) || addr_cyc[i] !== i + 1) begin
          fails++; $display("FAIL basic_addr[%0d]: got %0d@cyc%0d want %0d@cyc%0d", i, addr_val[i], addr_cyc[i], i, i + 1);
        end
      end
    end
    tests++;
    if (row_got.size() !== 4) begin
      fails++; $display("FAIL basic_row_count: got %0d want 4", row_got.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        tests++;
        if (row_got[r] !== exp_row(r) || idx_got[r] !== 2'(r) || row_cyc[r] !== 9 + r) begin
          fails++; $display("FAIL basic_row[%0d]: got %h idx%0d@cyc%0d want %h idx%0d@cyc%0d",
                            r, row_got[r], idx_got[r], row_cyc[r], exp_row(r), r, 9 + r);
        end
      end
    end
    tests++;
    if (done_cyc !== 13 || done_cnt !== 1) begin
      fails++; $display("FAIL basic_done: got cyc%0d count%0d want cyc13 count1", done_cyc, done_cnt);
    end
    for (int c = 0; c <= 14; c++) begin
      tests++;
      if (busy_log[c] !== (c >= 1 && c <= 13)) begin
        fails++; $display("FAIL basic_busy[cyc%0d]: got %b want %b", c, busy_log[c], (c >= 1 && c <= 13));
      end
    end
  endtask

  task automatic test_back_pressure();
    set_basic_matrix();
    load_matrix(7'd0, 1'b0);
    run_transfer(7'd0, 3, -1);
    tests++;
    if (unstable !== 0) begin
      fails++; $display("FAIL bp_stable: got %0d changes during stall want 0", unstable);
    end
    tests++;
    if (done_cyc !== 25) begin
      fails++; $display("FAIL bp_done_cycle: got %0d want 25", done_cyc);
    end
    for (int r = 0; r < 4; r++) begin
      tests++;
      if (r >= row_got.size() || row_got[r] !== exp_row(r) || row_cyc[r] !== 12 + 4 * r) begin
        fails++; $display("FAIL bp_row[%0d]: got %h@cyc%0d want %h@cyc%0d", r,
                          (r < row_got.size()) ? row_got[r] : 64'hx, (r < row_cyc.size()) ? row_cyc[r] : -1,
                          exp_row(r), 12 + 4 * r);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [6:0] ea;
    set_random_matrix();
    load_matrix(7'd125, 1'b1);
    run_transfer(7'd125, 0, -1);
    for (int i = 0; i < 7; i++) begin
      ea = 7'd125 + 7'(i);
      tests++;
      if (i >= addr_val.size() || addr_val[i] !== ea) begin
        fails++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, (i < addr_val.size()) ? addr_val[i] : 7'hx, ea);
      end
    end
    for (int r = 0; r < 4; r++) begin
      tests++;
      if (r >= row_got.size() || row_got[r] !== exp_row(r)) begin
        fails++; $display("FAIL wrap_row[%0d]: got %h want %h", r, (r < row_got.size()) ? row_got[r] : 64'hx, exp_row(r));
      end
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 40; i < 48; i++) ram[i] = {$urandom, $urandom};
    set_random_matrix();
    load_matrix(7'd10, 1'b1);
    run_transfer(7'd10, 0, 4);
    tests++;
    if (addr_val.size() !== 7) begin
      fails++; $display("FAIL busy_start_addr_count: got %0d want 7", addr_val.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++;
        if (addr_val[i] !== 7'(10 + i)) begin
          fails++; $display("FAIL busy_start_addr[%0d]: got %0d want %0d", i, addr_val[i], 10 + i);
        end
      end
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== 13) begin
      fails++; $display("FAIL busy_start_done: got count%0d cyc%0d want count1 cyc13", done_cnt, done_cyc);
    end
    for (int r = 0; r < 4; r++) begin
      tests++;
      if (r >= row_got.size() || row_got[r] !== exp_row(r)) begin
        fails++; $display("FAIL busy_start_row[%0d]: got %h want %h", r, (r < row_got.size()) ? row_got[r] : 64'hx, exp_row(r));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    set_random_matrix();
    load_matrix(7'd0, 1'b1);
    @(negedge clk);
    base_addr = 7'd0; start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (row_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL midrst_pre: got valid=%b busy=%b want 1 1", row_valid, busy);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, done} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got rd=%b addr=%0d v=%b data=%h idx=%0d busy=%b done=%b want all 0",
               mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, done);
    end
    row_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_random_matrix();
    load_matrix(7'd20, 1'b1);
    run_transfer(7'd20, 0, -1);
    tests++;
    if (done_cyc !== 13 || done_cnt !== 1) begin
      fails++; $display("FAIL midrst_rerun_done: got cyc%0d count%0d want cyc13 count1", done_cyc, done_cnt);
    end
    for (int r = 0; r < 4; r++) begin
      tests++;
      if (r >= row_got.size() || row_got[r] !== exp_row(r)) begin
        fails++; $display("FAIL midrst_row[%0d]: got %h want %h", r, (r < row_got.size()) ? row_got[r] : 64'hx, exp_row(r));
      end
    end
  endtask

  task automatic test_padding();
    set_basic_matrix();
    load_matrix(7'd0, 1'b1);
    run_transfer(7'd0, 0, -1);
    for (int r = 0; r < 4; r++) begin
      tests++;
      if (r >= row_got.size() || row_got[r] !== exp_row(r) || row_cyc[r] !== 9 + r) begin
        fails++; $display("FAIL pad_row[%0d]: got %h want %h", r, (r < row_got.size()) ? row_got[r] : 64'hx, exp_row(r));
      end
    end
    tests++;
    if (done_cyc !== 13) begin
      fails++; $display("FAIL pad_done: got %0d want 13", done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_addr_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    test_padding();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matc_diag_unpacker.md
# matc_diag_unpacker

Reads a finished 4x4 result matrix out of the C result RAM, where the systolic matmul stores it in anti-diagonal packed form (7 words), and rebuilds it into row-major order. It emits the four rows on a valid/ready stream toward the host or downstream logic. It sits on the C RAM read port, in place of the host `addr_pi` path, once `done_mat_mul` has fired.

## Interface
Parameters:
- `DWIDTH`, 16, element width; one RAM word is 4*DWIDTH.
- `AWIDTH`, 7, RAM address width.
- `MAT_SIZE`, 4, matrix dimension; fixed at 4, and no other value is supported.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `base_addr`  in  AWIDTH  RAM address of diagonal word 0; sampled with `start`.
- `mem_rd_en`  out  1  read strobe to the C RAM mux.
- `mem_addr`  out  AWIDTH  C RAM read address, registered.
- `mem_rdata`  in  4*DWIDTH  C RAM `q0`; valid one cycle after the address is presented.
- `row_valid`  out  1  a row is presented.
- `row_ready`  in  1  consumer accepts the row.
- `row_data`  out  4*DWIDTH  {C[r][3],C[r][2],C[r][1],C[r][0]}; lane 0 is at the LSBs.
- `row_idx`  out  2  row number r of `row_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after row 3 is accepted.

## Operation
- Packed format: diagonal word d (d = 0..6) holds C[k][d-k] in lane k, for every k with 0 <= d-k <= 3. All other lanes are padding and are ignored, whatever their value.
- FSM states and transitions:
  - IDLE: on `start`, latch `base_addr`, clear the counters, and go to READ.
  - READ: 7 cycles. Assert `mem_rd_en`, with `mem_addr` = base+d for d = 0..6. After d = 6, go to DRAIN.
  - DRAIN: 1 cycle. Capture the final word, then go to OUT.
  - OUT: present row `row_idx`. Advance on `row_valid && row_ready`. The handshake on row 3 goes to DONE.
  - DONE: 1 cycle. Pulse `done`, then go to IDLE.
- Capture: a one-cycle-delayed copy of (rd_en, d) qualifies `mem_rdata`. Each valid lane is written into a 16-entry element register file at [k][d-k].
- Address arithmetic is modulo 2^AWIDTH. Base 125 reads 125,126,127,0,1,2,3.
- `row_data` and `row_idx` stay stable while `row_valid && !row_ready`. `row_valid` does not drop until the row is accepted.
- `start` outside IDLE is ignored, with no queuing.
- Reset, including mid-operation, returns the FSM to IDLE immediately and clears all outputs and the element file. A transfer in progress is abandoned.
- Data is passed through unmodified; the block does no saturation or arithmetic.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `row_valid`=0, `row_data`=0, `row_idx`=0, `busy`=0, `done`=0.
- Cycle numbering: `start` is sampled at edge 0. Cycles 1..7 are READ, with `mem_addr` = base..base+6. Cycle 8 is DRAIN. `row_valid` first goes high in cycle 9.
- With `row_ready` held high, rows 0..3 appear in cycles 9..12, `done` pulses in cycle 13, and IDLE is reached in cycle 14. Start-to-done latency is 13 cycles plus the stall cycles.
- `busy` is high in cycles 1..13.
- There is no combinational path from `row_ready` to any output.

## Structure
- Shared package `matmul_pkg`:
  - Constants DWIDTH, AWIDTH, MAT_SIZE, and NUM_DIAGS = 2*MAT_SIZE-1.
  - The state enum {IDLE, READ, DRAIN, OUT, DONE}.
  - The lane/diagonal index helper constants.
- The block is one module with no sub-module. The element register file and the diagonal-to-[row][col] decode are inline, since the logic is too small to split.

## Test plan
- Basic unpack: preload words base=0 with C[i][j] = 16*i+j using the packed rule, set padding lanes to 16'hDEAD, and pulse `start` with `row_ready`=1.
  - Required: the seven reads hit addresses 0..6 in cycles 1..7.
  - Required: row 0 = {0003,0002,0001,0000} hex in cycle 9 through row 3 = {0033,0032,0031,0030} in cycle 12.
  - Required: `done` pulses in cycle 13.
- Back-pressure: repeat the basic unpack with `row_ready` low for 3 cycles on each row.
  - Required: each row is held stable during its stall.
  - Required: `done` pulses in cycle 25.
- Address wrap: run with base=125. Required: the addresses are 125,126,127,0,1,2,3, and the matrix is reconstructed correctly.
- Start while busy: pulse `start` with base=40 during cycle 4. Required: it is ignored, the addresses continue from the original base, and exactly one `done` occurs.
- Reset mid-run: deassert `reset_n` in cycle 10, asynchronously.
  - Required: all outputs drop to their reset values in the same cycle.
  - Required: a new `start` after reset completes normally with fresh data.
- Padding immunity: fill the padding lanes with random values. Required: the output rows are identical to the basic unpack case.
